// File: rtl/obstacle_engine.sv
// obstacle_engine: spawns ground obstacles from an LFSR, scrolls and retires them, ramps speed
// and flags dino overlap. Define SCORE_BCD_EN for a 4-digit packed BCD score.
module obstacle_engine #(
    parameter int unsigned SCREEN_W         = 640,
    parameter int unsigned OBS_W            = 20,
    parameter int unsigned OBS_H            = 40,
    parameter int unsigned DINO_X           = 60,
    parameter int unsigned DINO_W           = 20,
    parameter int unsigned SPEED_INIT       = 4,
    parameter int unsigned SPEED_MAX        = 10,
    parameter int unsigned SPEED_STEP_TICKS = 512,
    parameter int unsigned MIN_GAP          = 200,
    parameter int unsigned GAP_RAND_BITS    = 7,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_tick,
    input  logic [9:0]  dino_y,
    input  logic        game_over,
    output logic        obs0_valid,
    output logic [10:0] obs0_x,
    output logic        obs1_valid,
    output logic [10:0] obs1_x,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic        collision
);

    localparam logic [0:0] StRun    = 1'b0;
    localparam logic [0:0] StFrozen = 1'b1;

    localparam int unsigned TickW = (SPEED_STEP_TICKS > 1) ? $clog2(SPEED_STEP_TICKS) : 1;

    localparam logic [10:0] SpawnX    = 11'(SCREEN_W);
    localparam logic [11:0] ObsW      = 12'(OBS_W);
    localparam logic [9:0]  ObsH      = 10'(OBS_H);
    localparam logic [11:0] DinoLeft  = 12'(DINO_X);
    localparam logic [11:0] DinoRight = 12'(DINO_X + DINO_W);
    localparam logic [3:0]  SpeedInit = 4'(SPEED_INIT);
    localparam logic [3:0]  SpeedMax  = 4'(SPEED_MAX);
    localparam logic [9:0]  MinGap    = 10'(MIN_GAP);
    localparam logic [9:0]  GapSat    = 10'd1023;
    localparam logic [TickW-1:0] TickLast = TickW'(SPEED_STEP_TICKS - 1);
    localparam logic [15:0] LfsrMask  = 16'hB400;

    logic [0:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [1:0]       valid_q, valid_d;
    logic [10:0]      x_q [2];
    logic [10:0]      x_d [2];
    logic [3:0]       speed_q, speed_d;
    logic [15:0]      score_q, score_d;
    logic             collision_q, collision_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [9:0]       gap_cnt_q, gap_cnt_d;
    logic [9:0]       gap_target_q, gap_target_d;

    logic [1:0]       retire_cnt;
    logic [10:0]      gap_sum;

`ifdef SCORE_BCD_EN
    // Single BCD increment with per-digit carry; holds at 9999.
    function automatic logic [15:0] score_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        carry;
        r     = s;
        carry = 1'b1;
        if (s != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[4*d +: 4] == 4'd9) begin
                        r[4*d +: 4] = 4'd0;
                    end else begin
                        r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction
`else
    function automatic logic [15:0] score_inc(input logic [15:0] s);
        return (s == 16'hFFFF) ? s : s + 16'd1;
    endfunction
`endif

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        x_d          = x_q;
        speed_d      = speed_q;
        score_d      = score_q;
        tick_cnt_d   = tick_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        gap_target_d = gap_target_q;
        retire_cnt   = 2'd0;
        gap_sum      = 11'(gap_cnt_q) + 11'(speed_q);

        if (state_q == StRun && game_tick) begin
            if (game_over) begin
                state_d = StFrozen;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (valid_q[i]) begin
                        if (x_q[i] < 11'(speed_q)) begin
                            valid_d[i] = 1'b0;
                            retire_cnt = retire_cnt + 2'd1;
                        end else begin
                            x_d[i] = x_q[i] - 11'(speed_q);
                        end
                    end
                end

                gap_cnt_d = (gap_sum > 11'(GapSat)) ? GapSat : gap_sum[9:0];

                // Spawn decision uses the pre-tick gap but post-retire occupancy.
                if (gap_cnt_q >= gap_target_q && !(&valid_d)) begin
                    if (!valid_d[0]) begin
                        valid_d[0] = 1'b1;
                        x_d[0]     = SpawnX;
                    end else begin
                        valid_d[1] = 1'b1;
                        x_d[1]     = SpawnX;
                    end
                    gap_cnt_d    = '0;
                    gap_target_d = MinGap + 10'(lfsr_q[GAP_RAND_BITS-1:0]);
                end

                if (tick_cnt_q == TickLast) begin
                    tick_cnt_d = '0;
                    if (speed_q < SpeedMax) begin
                        speed_d = speed_q + 4'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TickW'(1);
                end

                if (retire_cnt >= 2'd1) begin
                    score_d = score_inc(score_q);
                end
                if (retire_cnt == 2'd2) begin
                    score_d = score_inc(score_inc(score_q));
                end
            end
        end
    end

    always_comb begin
        collision_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (valid_q[i] && (12'(x_q[i]) < DinoRight) && ((12'(x_q[i]) + ObsW) > DinoLeft) &&
                (dino_y < ObsH)) begin
                collision_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StRun;
            lfsr_q       <= LFSR_SEED;
            valid_q      <= 2'b00;
            x_q[0]       <= '0;
            x_q[1]       <= '0;
            speed_q      <= SpeedInit;
            score_q      <= '0;
            collision_q  <= 1'b0;
            tick_cnt_q   <= '0;
            gap_cnt_q    <= GapSat;
            gap_target_q <= MinGap;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            valid_q      <= valid_d;
            x_q[0]       <= x_d[0];
            x_q[1]       <= x_d[1];
            speed_q      <= speed_d;
            score_q      <= score_d;
            collision_q  <= collision_d;
            tick_cnt_q   <= tick_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_target_q <= gap_target_d;
        end
    end

    assign obs0_valid = valid_q[0];
    assign obs0_x     = x_q[0];
    assign obs1_valid = valid_q[1];
    assign obs1_x     = x_q[1];
    assign speed      = speed_q;
    assign score      = score_q;
    assign collision  = collision_q;

endmodule

// File: doc/obstacle_engine.md
Name: obstacle_engine

Overview:
Counterpart to game_fsm. It consumes game_fsm's dino_y and game_over and produces the collision input game_fsm needs. It spawns ground obstacles from an LFSR, scrolls them left on each game_tick, ramps scroll speed over time, counts obstacles cleared and detects dino/obstacle overlap. Its obstacle positions and score feed the VGA renderer and the score display.

Parameters:
SCREEN_W, 640, spawn x position (left edge of a new obstacle)
OBS_W, 20, obstacle width in px
OBS_H, 40, obstacle height in px; a dino with dino_y >= OBS_H clears it
DINO_X, 60, dino left edge in px (fixed)
DINO_W, 20, dino width in px
SPEED_INIT, 4, px per game_tick after reset
SPEED_MAX, 10, speed ceiling
SPEED_STEP_TICKS, 512, running game_ticks per speed increment
MIN_GAP, 200, minimum px scrolled between spawns
GAP_RAND_BITS, 7, LFSR bits added to MIN_GAP
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
game_tick  in  1  one-clock frame-rate strobe, shared with game_fsm
dino_y  in  10  dino height above ground from game_fsm; 0 = on ground
game_over  in  1  from game_fsm; freezes the engine
obs0_valid  out  1  slot 0 occupied
obs0_x  out  11  slot 0 left edge in px
obs1_valid  out  1  slot 1 occupied
obs1_x  out  11  slot 1 left edge in px
speed  out  4  current scroll speed in px/tick
score  out  16  obstacles cleared
collision  out  1  registered overlap flag, to game_fsm

Behaviour:
- Reset is synchronous, active-low, clk only. On reset:
  - obs*_valid=0, obs*_x=0, speed=SPEED_INIT, score=0, collision=0.
  - lfsr=LFSR_SEED, tick_cnt=0, gap_cnt=1023 (saturated, so the first tick spawns), gap_target=MIN_GAP.
  - state=RUN.
- Reset asserted mid-game (RUN or FROZEN) clears everything at the next edge.
- States:
  - RUN: moves to FROZEN on a clock where game_ticks=1 and game_over=1.
  - FROZEN: absorbing; left only by reset.
  - In FROZEN nothing moves, spawns, scores or speeds up. Outputs hold.
- LFSR: 16-bit Galois, mask 16'hB400, advances every clock in both states.
- On a game_tick in RUN, all updates land on the same edge, evaluated in this order:
  1. Move/retire: for each valid slot, if x < speed, the slot clears valid and score increments (+1 per retiring slot, so 2 if both retire). Otherwise x <= x - speed.
  2. Gap: gap_cnt <= min(gap_cnt + speed, 1023).
  3. Spawn: if gap_cnt (pre-tick value) >= gap_target and a slot is free after step 1, fill the lowest free slot with x=SCREEN_W, valid=1. Then gap_cnt <= 0 and gap_target <= MIN_GAP + lfsr[GAP_RAND_BITS-1:0]. At most one spawn per tick. If no slot is free, the spawn is deferred and gap_cnt keeps saturating.
  4. Speed: tick_cnt increments. At SPEED_STEP_TICKS-1 it wraps to 0 and speed <= min(speed+1, SPEED_MAX).
- Score saturates at 16'hFFFF.
- Collision is recomputed every clock, in both states, one-clock latency from inputs and positions. It is the OR over valid slots of (x < DINO_X+DINO_W) && (x + OBS_W > DINO_X) && (dino_y < OBS_H). Not sticky.
- Arithmetic: x+OBS_W is computed in 12 bits, so no wrap.
- game_tick=0 clocks change only lfsr and collision.

Optional Feature:
SCORE_BCD_EN
- Defined: score holds 4 packed BCD digits (score[3:0] is units). Each increment carries per digit, and a 2-retire tick adds 2 in BCD. Saturates at 16'h9999.
- Undefined: plain binary score as described in Behaviour.

Test Plan:
1. Reset with rst_n=0 for 2 clocks, then release -> valid=0/0, speed=4, score=0, collision=0. First game_tick -> obs0_valid=1, obs0_x=640, obs1_valid=0.
2. dino_y=0, ticks continue after spawn -> obs0_x=640-4k. After 141 further ticks obs0_x=76, and collision=1 one clock later. Hold dino_y=50 instead -> collision stays 0 through x=40.
3. Run with dino_y=50 until obs0 retires (x<4 at tick) -> obs0_valid=0 and score=1 on the same edge. The second slot spawns once gap_cnt >= gap_target, where gap_target is computed from the LFSR model.
4. Speed ramp: 512 running ticks -> speed=5. After 6*512 ticks -> speed=10, and it stays 10 after further 512s.
5. Freeze: collision=1, then game_tick with game_over=1 -> positions, score and speed unchanged over 50 further ticks. rst_n=0 one clock -> full reset values.
6. With SCORE_BCD_EN: drive score to 16'h0009 and retire one -> 16'h0010; 16'h9999 plus a retirement -> stays 16'h9999.
